// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-master state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    WR_IDLE      = 3'b001,
    WR_ADDR_DATA = 3'b010,
    WR_RESP      = 3'b100
  } wr_state_e;

endpackage

// File: rtl/axi_lite_wr_master.sv
// AXI4-Lite single-outstanding write master: command in, AW+W out, B back as done_o/resp_o.
// Optional watchdog: define AXI_WR_TIMEOUT_EN to abort a stalled transaction with SLVERR.
module axi_lite_wr_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    done_o,
  output logic [1:0]              resp_o,
  output logic                    busy_o,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_e             r_state, w_state_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid, w_wvalid_nxt;
  logic                  r_bready, w_bready_nxt;
  logic                  r_aw_done, w_aw_done_nxt;
  logic                  r_w_done, w_w_done_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_busy;
  logic [1:0]            r_resp, w_resp_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [STRB_W-1:0]     r_wstrb, w_wstrb_nxt;

  logic w_aw_hs, w_w_hs, w_b_hs;

  assign w_aw_hs = r_awvalid & AWREADY;
  assign w_w_hs  = r_wvalid & WREADY;
  assign w_b_hs  = r_bready & BVALID;

`ifdef AXI_WR_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_tmo;

  // Held at zero while idle, so it restarts from zero on every accept.
  assign w_cnt_nxt = (r_state == WR_IDLE) ? '0 : r_cnt + CNT_W'(1);
  // A real B handshake in the final cycle wins over the watchdog.
  assign w_tmo     = (r_state != WR_IDLE) && (r_cnt == TMO_LAST) && !w_b_hs;

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) r_cnt <= '0;
    else         r_cnt <= w_cnt_nxt;
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_bready_nxt  = r_bready;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_done_nxt    = 1'b0;
    w_resp_nxt    = r_resp;
    w_awaddr_nxt  = r_awaddr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    case (r_state)
      WR_IDLE: begin
        if (cmd_valid) begin
          w_awaddr_nxt  = cmd_addr;
          w_wdata_nxt   = cmd_data;
          w_wstrb_nxt   = cmd_strb;
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_state_nxt   = WR_ADDR_DATA;
        end
      end
      WR_ADDR_DATA: begin
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (w_b_hs) begin
          w_bready_nxt = 1'b0;
          w_resp_nxt   = BRESP;
          w_done_nxt   = 1'b1;
          w_state_nxt  = WR_IDLE;
        end
      end
      default: begin
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_bready_nxt  = 1'b0;
        w_state_nxt   = WR_IDLE;
      end
    endcase
`ifdef AXI_WR_TIMEOUT_EN
    if (w_tmo) begin
      w_awvalid_nxt = 1'b0;
      w_wvalid_nxt  = 1'b0;
      w_bready_nxt  = 1'b0;
      w_done_nxt    = 1'b1;
      w_resp_nxt    = RESP_SLVERR;
      w_state_nxt   = WR_IDLE;
    end
`endif
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_state   <= WR_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_resp    <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt != WR_IDLE);
      r_resp    <= w_resp_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
    end
  end

  assign cmd_ready = (r_state == WR_IDLE);
  assign done_o    = r_done;
  assign resp_o    = r_resp;
  assign busy_o    = r_busy;
  assign AWADDR    = r_awaddr;
  assign AWVALID   = r_awvalid;
  assign WDATA     = r_wdata;
  assign WSTRB     = r_wstrb;
  assign WVALID    = r_wvalid;
  assign BREADY    = r_bready;

endmodule

// File: tb/tb_axi_lite_wr_master.sv
// Bench for axi_lite_wr_master: directed timing cases plus a randomized slave, checked
// against a transaction-queue model. Timeout case runs when AXI_WR_TIMEOUT_EN is defined.
module tb_axi_lite_wr_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_strb;
  logic          done_o, busy_o;
  logic [1:0]    resp_o;
  logic [AW-1:0] AWADDR;
  logic          AWVALID, AWREADY;
  logic [DW-1:0] WDATA;
  logic [SW-1:0] WSTRB;
  logic          WVALID, WREADY;
  logic [1:0]    BRESP;
  logic          BVALID, BREADY;

  always #5 ACLK = ~ACLK;

  axi_lite_wr_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .done_o(done_o), .resp_o(resp_o), .busy_o(busy_o),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one queue entry per accepted command, retired on done_o.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } cmd_t;

  cmd_t          q[$];
  int            n_acc = 0, n_done = 0, n_abort = 0;
  int            mode = 2;   // 0: zero-latency slave, 1: random slave, 2: driven by hand
  logic          aw_seen = 0, w_seen = 0, b_seen = 0;
  logic [1:0]    b_resp = 0;
  logic          aw_pend = 0, w_pend = 0;
  logic [AW-1:0] aw_hold;
  logic [DW-1:0] w_hold_d;
  logic [SW-1:0] w_hold_s;

  initial forever begin
    @(posedge ACLK); #2;
    if (mode == 0) begin
      {AWREADY, WREADY, BVALID} = 3'b111;
      BRESP = 2'b00;
    end else if (mode == 1) begin
      AWREADY = 1'($urandom_range(0, 1));
      WREADY  = 1'($urandom_range(0, 1));
      BVALID  = 1'($urandom_range(0, 1));
      BRESP   = 2'($urandom_range(0, 3));
    end
  end

  initial forever begin
    @(negedge ACLK);
    if (!ARESET) begin
      q.delete();
      {aw_seen, w_seen, b_seen, aw_pend, w_pend} = '0;
    end else begin
      chk("rdy_vs_busy", cmd_ready, !busy_o);
      if (aw_pend && !done_o) chk("aw_hold", {AWVALID, AWADDR}, {1'b1, aw_hold});
      if (w_pend && !done_o)  chk("w_hold", {WVALID, WSTRB, WDATA}, {1'b1, w_hold_s, w_hold_d});
      if (AWVALID && AWREADY) begin
        chk("aw_once", aw_seen, 0);
        chk("aw_q", q.size() != 0, 1);
        if (q.size() != 0) chk("awaddr", AWADDR, q[0].addr);
        aw_seen = 1;
      end
      if (WVALID && WREADY) begin
        chk("w_once", w_seen, 0);
        chk("w_q", q.size() != 0, 1);
        if (q.size() != 0) chk("wdata", {WSTRB, WDATA}, {q[0].strb, q[0].data});
        w_seen = 1;
      end
      if (BREADY) chk("bready_gate", aw_seen && w_seen, 1);
      if (BVALID && BREADY) begin
        b_seen = 1;
        b_resp = BRESP;
      end
      if (done_o) begin
        chk("done_q", q.size() != 0, 1);
`ifdef AXI_WR_TIMEOUT_EN
        chk("resp", resp_o, b_seen ? b_resp : 2'b10);
`else
        chk("done_after_b", b_seen, 1);
        chk("resp", resp_o, b_resp);
`endif
        if (q.size() != 0) void'(q.pop_front());
        n_done++;
        {aw_seen, w_seen, b_seen} = '0;
      end
      if (cmd_valid && cmd_ready) begin
        chk("acc_idle", q.size(), 0);
        q.push_back('{cmd_addr, cmd_data, cmd_strb});
        n_acc++;
        {aw_seen, w_seen, b_seen} = '0;
      end
      aw_pend  = AWVALID && !AWREADY;
      aw_hold  = AWADDR;
      w_pend   = WVALID && !WREADY;
      w_hold_d = WDATA;
      w_hold_s = WSTRB;
    end
  end

  // Returns at the negedge of the accept cycle with cmd_valid still high.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic acc = 0;
    @(posedge ACLK); #2;
    cmd_valid = 1; cmd_addr = a; cmd_data = d; cmd_strb = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (cmd_ready) begin acc = 1; break; end
    end
    chk("cmd_accept", acc, 1);
  endtask

  task automatic wait_done(input int max);
    logic got = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge ACLK);
      if (done_o) begin got = 1; break; end
    end
    chk("done_seen", got, 1);
  endtask

  task automatic step();
    @(posedge ACLK); #2;
  endtask

  localparam logic [3:0] T2 [6] = '{4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0001};
  localparam logic [3:0] T3 [4] = '{4'b1100, 4'b1100, 4'b0010, 4'b0001};
  localparam logic [1:0] T5 [6] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};

  initial begin
    cmd_valid = 0; cmd_addr = 0; cmd_data = 0; cmd_strb = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;

    // reset state
    repeat (2) @(negedge ACLK);
    chk("rst_ctl", {AWVALID, WVALID, BREADY, done_o, busy_o, resp_o}, 0);
    chk("rst_payload", {AWADDR, WSTRB}, 0);
    chk("rst_wdata", WDATA, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    step(); ARESET = 1;

    // zero-latency slave: AW/W at N+1, B at N+2, done at N+3
    mode = 0;
    send_cmd(32'h4, 32'hA5A5_1234, 4'hF);
    step(); cmd_valid = 0; @(negedge ACLK);
    chk("t1_n1_valid", {AWVALID, WVALID, BREADY, cmd_ready}, 4'b1100);
    chk("t1_n1_payload", {AWADDR, WDATA}, {32'h4, 32'hA5A5_1234});
    step(); @(negedge ACLK);
    chk("t1_n2", {AWVALID, WVALID, BREADY, done_o}, 4'b0010);
    step(); @(negedge ACLK);
    chk("t1_n3", {done_o, resp_o, cmd_ready, busy_o}, 5'b1_00_1_0);
    step(); @(negedge ACLK);
    chk("t1_n4", done_o, 0);

    // AWREADY late by 3 cycles, WREADY immediate
    mode = 2; AWREADY = 0; WREADY = 1; BVALID = 1; BRESP = 2'b00;
    send_cmd(32'h100, 32'hDEAD_0001, 4'h3);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) cmd_valid = 0;
      if (k == 4) AWREADY = 1;
      if (k == 5) AWREADY = 0;
      @(negedge ACLK);
      chk($sformatf("t2_k%0d", k), {AWVALID, WVALID, BREADY, done_o}, T2[k-1]);
      if (k >= 2 && k <= 4) chk($sformatf("t2_addr_k%0d", k), AWADDR, 32'h100);
    end

    // early BVALID with SLVERR is ignored until both handshakes
    AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b10;
    send_cmd(32'h200, 32'h1357_9BDF, 4'h5);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) cmd_valid = 0;
      if (k == 2) begin AWREADY = 1; WREADY = 1; end
      if (k == 3) begin AWREADY = 0; WREADY = 0; end
      @(negedge ACLK);
      chk($sformatf("t3_k%0d", k), {AWVALID, WVALID, BREADY, done_o}, T3[k-1]);
    end
    chk("t3_resp", resp_o, 2'b10);

    // reset mid-transaction aborts silently
    AWREADY = 0; WREADY = 0; BVALID = 0;
    send_cmd(32'h300, 32'h0BAD_F00D, 4'hF);
    step(); cmd_valid = 0; @(negedge ACLK);
    chk("t4_pre", {AWVALID, WVALID, busy_o}, 3'b111);
    #1 ARESET = 0; n_abort++;
    #1 chk("t4_async", {AWVALID, WVALID, busy_o, BREADY}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      chk("t4_no_done", done_o, 0);
    end
    step(); ARESET = 1;
    mode = 0;
    send_cmd(32'h304, 32'h600D_600D, 4'hC);
    step(); cmd_valid = 0;
    wait_done(20);
    chk("t4_resp", resp_o, 2'b00);

    // back-to-back: second accepted in the done_o cycle
    send_cmd(32'h400, 32'h1111_1111, 4'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin cmd_addr = 32'h404; cmd_data = 32'h2222_2222; cmd_strb = 4'h2; end
      if (k == 4) cmd_valid = 0;
      @(negedge ACLK);
      chk($sformatf("t5_k%0d", k), {cmd_ready, done_o}, T5[k-1]);
    end

    // randomized slave and commands, including strb=0
    mode = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge ACLK);
      send_cmd($urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
      step(); cmd_valid = 0;
      wait_done(300);
    end

`ifdef AXI_WR_TIMEOUT_EN
    // AWREADY never rises: SLVERR after 16 cycles in flight
    mode = 2;
    repeat (3) @(negedge ACLK);
    AWREADY = 0; WREADY = 1; BVALID = 0;
    send_cmd(32'h500, 32'h5555_AAAA, 4'hF);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 1) cmd_valid = 0;
      @(negedge ACLK);
      if (k < 17) chk($sformatf("t6_k%0d", k), {done_o, AWVALID, busy_o}, 3'b011);
      else begin
        chk("t6_end", {done_o, AWVALID, WVALID, BREADY, busy_o, cmd_ready}, 6'b100001);
        chk("t6_resp", resp_o, 2'b10);
      end
    end
`endif

    repeat (3) @(negedge ACLK);
    chk("txn_count", n_done, n_acc - n_abort);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
